// File: rtl/dma_split_scheduler.sv
// DMA split scheduler: cuts a frontend transfer into destination-aligned
// chunks and steers each one to the backend that owns that L1 interleave slot.
module dma_split_scheduler #(
  parameter int unsigned NumBackends = 4,
  parameter int unsigned ChunkBytes  = 1024,
  parameter int unsigned AddrWidth   = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic [AddrWidth-1:0]   req_src_i,
  input  logic [AddrWidth-1:0]   req_dst_i,
  input  logic [31:0]            req_len_i,
  output logic [NumBackends-1:0] be_valid_o,
  input  logic [NumBackends-1:0] be_ready_i,
  output logic [AddrWidth-1:0]   be_src_o,
  output logic [AddrWidth-1:0]   be_dst_o,
  output logic [31:0]            be_len_o,
  input  logic [NumBackends-1:0] be_done_i,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int unsigned OffW = $clog2(ChunkBytes);
  localparam int unsigned IdxW = $clog2(NumBackends);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_e;

  state_e               state_q;
  logic [AddrWidth-1:0] src_q;
  logic [AddrWidth-1:0] dst_q;
  logic [31:0]          rem_q;
  logic [31:0]          cnt_q;
  logic                 done_q;

  logic [31:0]          span;
  logic [31:0]          chunk_len;
  logic [IdxW-1:0]      tgt;
  logic                 issuing;
  logic                 hs;
  logic [31:0]          pop;
  logic [31:0]          cnt_inc;
  logic [31:0]          cnt_nxt;

  // A chunk never crosses a ChunkBytes boundary of the destination.
  always_comb begin
    span      = 32'(ChunkBytes) - 32'(dst_q[OffW-1:0]);
    chunk_len = (rem_q < span) ? rem_q : span;
  end

  assign tgt     = dst_q[OffW +: IdxW];
  assign issuing = (state_q == ISSUE);
  assign hs      = issuing && be_ready_i[tgt];

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < NumBackends; i++) begin
      pop = pop + 32'(be_done_i[i]);
    end
  end

  // Issue and completions net in one cycle; never drop below zero.
  always_comb begin
    cnt_inc = cnt_q + 32'(hs);
    cnt_nxt = (cnt_inc > pop) ? (cnt_inc - pop) : '0;
  end

  always_comb begin
    be_valid_o = '0;
    if (issuing) begin
      be_valid_o[tgt] = 1'b1;
    end
  end

  assign be_src_o    = issuing ? src_q : '0;
  assign be_dst_o    = issuing ? dst_q : '0;
  assign be_len_o    = issuing ? chunk_len : '0;
  assign req_ready_o = (state_q == IDLE);
  assign busy_o      = (state_q != IDLE);
  assign done_o      = done_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            if (req_len_i == '0) begin
              done_q <= 1'b1;
            end else begin
              src_q   <= req_src_i;
              dst_q   <= req_dst_i;
              rem_q   <= req_len_i;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt_q <= cnt_nxt;
          if (hs) begin
            src_q <= src_q + AddrWidth'(chunk_len);
            dst_q <= dst_q + AddrWidth'(chunk_len);
            rem_q <= rem_q - chunk_len;
            if (rem_q == chunk_len) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          cnt_q <= cnt_nxt;
          if (cnt_nxt == '0) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dma_split_scheduler.sv
// Directed bench for dma_split_scheduler with 4 backends and 256-byte chunks.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_dma_split_scheduler;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_src;
  logic [31:0] req_dst;
  logic [31:0] req_len;
  logic [3:0]  be_valid;
  logic [3:0]  be_ready;
  logic [31:0] be_src;
  logic [31:0] be_dst;
  logic [31:0] be_len;
  logic [3:0]  be_done;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  dma_split_scheduler #(
    .NumBackends(4),
    .ChunkBytes (256),
    .AddrWidth  (32)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_src_i  (req_src),
    .req_dst_i  (req_dst),
    .req_len_i  (req_len),
    .be_valid_o (be_valid),
    .be_ready_i (be_ready),
    .be_src_o   (be_src),
    .be_dst_o   (be_dst),
    .be_len_o   (be_len),
    .be_done_i  (be_done),
    .busy_o     (busy),
    .done_o     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] want);
    checks++;
    assert (obs === want) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // valid, src, dst, len packed as one 100-bit word
  task automatic chk_be(input string tag, input logic [3:0] v,
                        input logic [31:0] s, input logic [31:0] d,
                        input logic [31:0] l);
    chk(tag, {be_valid, be_src, be_dst, be_len}, {v, s, d, l});
  endtask

  task automatic chk_st(input string tag, input logic b,
                        input logic dn, input logic rdy);
    chk(tag, {busy, done, req_ready}, {b, dn, rdy});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] d,
                      input logic [31:0] l);
    req_valid = 1'b1;
    req_src   = s;
    req_dst   = d;
    req_len   = l;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_src   = '0;
    req_dst   = '0;
    req_len   = '0;
    be_ready  = '0;
    be_done   = '0;
    step();
    step();
    chk_st("rst_status", 1'b0, 1'b0, 1'b1);
    chk_be("rst_be", 4'b0000, 32'h0, 32'h0, 32'h0);
    rst = 1'b0;
    step();

    // three aligned chunks, all backends ready
    be_ready = 4'hF;
    send(32'h8000, 32'h100, 32'h300);
    chk_st("t1_busy", 1'b1, 1'b0, 1'b0);
    chk_be("t1_c0", 4'b0010, 32'h8000, 32'h100, 32'h100);
    step();
    chk_be("t1_c1", 4'b0100, 32'h8100, 32'h200, 32'h100);
    step();
    chk_be("t1_c2", 4'b1000, 32'h8200, 32'h300, 32'h100);
    step();
    chk_be("t1_drain_be", 4'b0000, 32'h0, 32'h0, 32'h0);
    chk_st("t1_drain", 1'b1, 1'b0, 1'b0);
    be_done = 4'b0010;
    step();
    be_done = 4'b0100;
    step();
    chk_st("t1_wait2", 1'b1, 1'b0, 1'b0);
    be_done = 4'b1000;
    step();
    be_done = 4'b0000;
    chk_st("t1_done", 1'b0, 1'b1, 1'b1);
    step();
    chk_st("t1_done_end", 1'b0, 1'b0, 1'b1);

    // unaligned destination splits at the 256-byte boundary
    send(32'h8000, 32'h1F0, 32'h20);
    chk_be("t2_c0", 4'b0010, 32'h8000, 32'h1F0, 32'h10);
    step();
    chk_be("t2_c1", 4'b0100, 32'h8010, 32'h200, 32'h10);
    step();
    chk_st("t2_drain", 1'b1, 1'b0, 1'b0);
    be_done = 4'b0110;
    step();
    be_done = 4'b0000;
    chk_st("t2_done", 1'b0, 1'b1, 1'b1);

    // zero-length transfer
    step();
    send(32'h1234, 32'h5678, 32'h0);
    chk_st("t3_done", 1'b0, 1'b1, 1'b1);
    chk_be("t3_be", 4'b0000, 32'h0, 32'h0, 32'h0);
    step();
    chk_st("t3_done_end", 1'b0, 1'b0, 1'b1);

    // backend 2 stalls for 5 cycles; others report ready
    be_ready = 4'b1011;
    send(32'h4000, 32'h200, 32'h200);
    for (int i = 0; i < 5; i++) begin
      chk_be($sformatf("t4_stall%0d", i), 4'b0100,
             32'h4000, 32'h200, 32'h100);
      if (i < 4) step();
    end
    be_ready = 4'hF;
    step();
    chk_be("t4_resume", 4'b1000, 32'h4100, 32'h300, 32'h100);
    step();
    chk_st("t4_drain", 1'b1, 1'b0, 1'b0);
    be_done = 4'b1100;
    step();
    be_done = 4'b0000;
    chk_st("t4_done", 1'b0, 1'b1, 1'b1);
    step();

    // last handshake nets against two completions
    send(32'h1000, 32'h0, 32'h300);
    chk_be("t5_c0", 4'b0001, 32'h1000, 32'h0, 32'h100);
    step();
    chk_be("t5_c1", 4'b0010, 32'h1100, 32'h100, 32'h100);
    step();
    chk_be("t5_c2", 4'b0100, 32'h1200, 32'h200, 32'h100);
    be_done = 4'b0011;
    step();
    be_done = 4'b0000;
    chk_st("t5_drain", 1'b1, 1'b0, 1'b0);
    step();
    chk_st("t5_hold", 1'b1, 1'b0, 1'b0);
    be_done = 4'b0100;
    step();
    be_done = 4'b0000;
    chk_st("t5_done", 1'b0, 1'b1, 1'b1);
    step();
    chk_st("t5_done_end", 1'b0, 1'b0, 1'b1);

    // reset in the middle of a 4-chunk transfer
    send(32'h2000, 32'h0, 32'h400);
    chk_be("t6_c0", 4'b0001, 32'h2000, 32'h0, 32'h100);
    step();
    chk_be("t6_c1", 4'b0010, 32'h2100, 32'h100, 32'h100);
    rst = 1'b1;
    #1;
    chk_be("t6_rst_be", 4'b0000, 32'h0, 32'h0, 32'h0);
    chk_st("t6_rst_st", 1'b0, 1'b0, 1'b1);
    step();
    rst = 1'b0;
    be_done = 4'b0011;
    step();
    be_done = 4'b0000;
    chk_st("t6_late_done", 1'b0, 1'b0, 1'b1);
    step();
    chk_st("t6_quiet", 1'b0, 1'b0, 1'b1);
    send(32'h3000, 32'h0, 32'h10);
    chk_be("t6_next", 4'b0001, 32'h3000, 32'h0, 32'h10);
    step();
    be_done = 4'b0001;
    step();
    be_done = 4'b0000;
    chk_st("t6_next_done", 1'b0, 1'b1, 1'b1);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dma_split_scheduler.md
DMA_SPLIT_SCHEDULER -- requirements
Module: dma_split_scheduler

Interface
REQ-001 SHALL have parameter NumBackends, default 4, number of DMA backends in the group (power of two, >=2).
REQ-002 SHALL have parameter ChunkBytes, default 1024, L1 interleave span served by one backend (power of two).
REQ-003 SHALL have parameter AddrWidth, default 32, address width.
REQ-004 SHALL have port clk_i  input  1  clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have ports req_valid_i  input  1 and req_ready_o  output  1: frontend transfer handshake.
REQ-007 SHALL have ports req_src_i, req_dst_i  input  AddrWidth each, and req_len_i  input  32: transfer source, destination, byte count.
REQ-008 SHALL have ports be_valid_o  output  NumBackends and be_ready_i  input  NumBackends: per-backend chunk handshake, at most one be_valid_o bit set.
REQ-009 SHALL have ports be_src_o, be_dst_o  output  AddrWidth each, and be_len_o  output  32: chunk fields shared by all backends.
REQ-010 SHALL have port be_done_i  input  NumBackends: one-cycle pulse per completed chunk per backend.
REQ-011 SHALL have ports busy_o  output  1 (transfer in progress) and done_o  output  1 (one-cycle pulse at transfer completion).

Function
REQ-012 SHALL implement FSM IDLE, ISSUE, DRAIN; req_ready_o = 1 only in IDLE.
REQ-013 SHALL, on req_valid_i & req_ready_o, latch src, dst, remaining=len and go to ISSUE, or, if len==0, stay IDLE and pulse done_o next cycle.
REQ-014 SHALL compute chunk length = min(remaining, ChunkBytes - (dst mod ChunkBytes)) so no chunk crosses a ChunkBytes boundary of dst.
REQ-015 SHALL target backend index = (dst / ChunkBytes) mod NumBackends.
REQ-016 SHALL assert be_valid_o[target] in ISSUE the cycle after acceptance (latency 1) with be_src_o, be_dst_o, be_len_o = current src, dst, chunk length.
REQ-017 SHALL hold be_valid_o and all chunk fields stable until be_ready_i[target] is sampled high; be_ready_i of non-targeted backends SHALL be ignored.
REQ-018 SHALL, on chunk handshake, advance src and dst by chunk length, subtract it from remaining, and increment the outstanding counter; next chunk valid the following cycle (max one chunk per cycle).
REQ-019 SHALL go to DRAIN when the handshaken chunk leaves remaining==0.
REQ-020 SHALL decrement the outstanding counter by popcount(be_done_i) each cycle; same-cycle issue and completions SHALL net (+1 - popcount).
REQ-021 SHALL, in DRAIN, return to IDLE and pulse done_o for one cycle the cycle after the counter reaches 0 (counting completions in that same cycle).
REQ-022 SHALL ignore be_done_i in IDLE and saturate the outstanding counter at 0 (no underflow).
REQ-023 SHALL use a 32-bit outstanding counter; address arithmetic SHALL wrap modulo 2^AddrWidth.
REQ-024 SHALL drive busy_o = 1 in ISSUE and DRAIN, 0 in IDLE.
REQ-025 SHALL deassert be_valid_o entirely outside ISSUE.

Reset
REQ-026 SHALL, while rst_i is high, immediately force FSM to IDLE, counter and latched fields to 0, be_valid_o=0, be_src_o=be_dst_o=be_len_o=0, done_o=0, busy_o=0, req_ready_o=1.
REQ-027 SHALL, on reset mid-transfer, abandon the transfer without done_o; completions arriving after reset SHALL be ignored per REQ-022.

Verification (NumBackends=4, ChunkBytes=256)
REQ-028 SHALL cover: src=0x8000, dst=0x100, len=0x300, all ready -> chunks (0x8000,0x100,0x100) on be 1, (0x8100,0x200,0x100) on be 2, (0x8200,0x300,0x100) on be 3 in consecutive cycles; three done pulses -> done_o one cycle after the third.
REQ-029 SHALL cover: src=0x8000, dst=0x1F0, len=0x20 -> (0x8000,0x1F0,0x10) on be 1, then (0x8010,0x200,0x10) on be 2.
REQ-030 SHALL cover: len=0 -> no be_valid_o, done_o high exactly one cycle after acceptance, busy_o stays 0.
REQ-031 SHALL cover: be_ready_i[2]=0 for 5 cycles while be_valid_o[2]=1 -> fields stable all 5 cycles, no other be_valid_o bit set, issue resumes the cycle after ready.
REQ-032 SHALL cover: last chunk handshake in same cycle as be_done_i=4'b0011 with counter=2 -> counter 1, DRAIN; final done -> done_o next cycle.
REQ-033 SHALL cover: rst_i pulsed during ISSUE of a 4-chunk transfer -> all outputs at reset values, req_ready_o=1, late be_done_i ignored, no done_o.
